// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared common-data-bus types for the producer and the reservation stations
package cdb_arbiter_pkg;
  typedef enum logic [1:0] {FU_ALU, FU_BRANCH, FU_MUL, FU_LSU} e_functional_unit;
  localparam int NUM_FUNCTIONAL_UNITS = 1 << $bits(e_functional_unit);
  localparam int CDB_DATA_WIDTH = 32;
  typedef struct packed {
    logic en;
    logic [CDB_DATA_WIDTH-1:0] data;
    e_functional_unit rs;
  } cdb_bcast;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with a rotating priority pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_d, ptr_q, idx;
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx = ptr_q;
    // Scan from the farthest slot back to ptr so the nearest request wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (advance && req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        ptr_d = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one finished station per cycle and broadcasts its result one cycle later
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [NUM_RS-1:0]                    ready_i,
  input  logic [NUM_RS-1:0][DATA_WIDTH-1:0]    result_i,
  output logic [NUM_RS-1:0]                    retire_o,
  output logic                                 bcast_en_o,
  output logic [DATA_WIDTH-1:0]                bcast_data_o,
  output e_functional_unit                     bcast_rs_o
);
  localparam int FW = $bits(e_functional_unit);
  if (NUM_RS > NUM_FUNCTIONAL_UNITS || DATA_WIDTH != CDB_DATA_WIDTH) begin : g_bad_cfg
    $error("cdb_arbiter: NUM_RS exceeds tag encodings or DATA_WIDTH differs from bus width");
  end
  logic [NUM_RS-1:0] grant;
  cdb_bcast bcast_d, bcast_q;
  rr_arbiter #(.N(NUM_RS)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (ready_i),
    .advance(!(flush_i || rst)),
    .grant  (grant)
  );
  // Only the granted lane is selected, so undriven results on idle stations never propagate.
  always_comb begin
    bcast_d = '{en: 1'b0, data: bcast_q.data, rs: bcast_q.rs};
    for (int i = 0; i < NUM_RS; i++)
      if (grant[i]) bcast_d = '{en: 1'b1, data: result_i[i], rs: e_functional_unit'(FW'(i))};
  end
  always_ff @(posedge clk) bcast_q <= rst ? '{en: 1'b0, data: '0, rs: FU_ALU} : bcast_d;
  assign retire_o = grant;
  assign bcast_en_o = bcast_q.en;
  assign bcast_data_o = bcast_q.data;
  assign bcast_rs_o = bcast_q.rs;
  a_onehot: assert property (@(posedge clk) $onehot0(retire_o));
  a_ready: assert property (@(posedge clk) (retire_o & ~ready_i) == '0);
endmodule
